// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster sequencer producing de/hsync/vsync/rgb with valid/ready pixel fetch and underrun fill
module video_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [11:0] h_cnt, v_cnt;
  logic h_end, v_end, miss;
  always_comb begin
    h_end = h_cnt == H_LAST;
    v_end = v_cnt == V_LAST;
    pix_ready = (state != IDLE) && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    miss = pix_ready && !pix_valid;
    state_nx = (state == IDLE) ? (enable ? RUN : IDLE) :
               enable ? RUN :
               ((state == DRAIN) && h_end && v_end) ? IDLE : DRAIN;
  end
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
      de <= 1'b0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      {red, green, blue} <= '0;
      x <= '0;
      y <= '0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state <= state_nx;
      h_cnt <= ((state == IDLE) || h_end) ? '0 : h_cnt + 12'd1;
      v_cnt <= (state == IDLE) ? '0 : h_end ? (v_end ? '0 : v_cnt + 12'd1) : v_cnt;
      de <= pix_ready;
      hsync <= ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
      vsync <= ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
      {red, green, blue} <= !pix_ready ? '0 : pix_valid ? pix_data : FILL_RGB;
      x <= h_cnt;
      y <= v_cnt;
      frame_start <= (state != IDLE) && (h_cnt == '0) && (v_cnt == '0);
      underrun <= miss;
      underrun_cnt <= underrun_cnt + 16'(miss && (underrun_cnt != 16'hFFFF));
    end
  end
endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl: directed plus randomized checks of video_timing_ctrl against a raster-position model
module tb_video_timing_ctrl;
  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [23:0] FILL = 24'hA5C3E1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, enable, pix_valid;
  logic [23:0] pix_data;
  logic pix_ready, de, hsync, vsync, frame_start, underrun;
  logic [7:0] red, green, blue;
  logic [11:0] x, y;
  logic [15:0] underrun_cnt;
  logic s_rst;
  logic s_ready, s_de, s_hsync, s_vsync, s_fs, s_underrun;
  logic [7:0] s_red, s_green, s_blue;
  logic [11:0] s_x, s_y;
  logic [15:0] s_cnt;
  int checks = 0, failures = 0;
  int de_n, fs_n, hs_n, vs_n, ur_n, hs_first_x;
  int s_pulses = 0;
  bit m_run, m_drain;
  int m_p, m_cnt;
  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .FILL_RGB(FILL)
  ) dut (
    .pix_clk(clk), .rst(rst), .enable(enable), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .de(de), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .x(x), .y(y),
    .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );
  video_timing_ctrl #(
    .H_ACTIVE(250), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(250), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FILL_RGB(24'h000000)
  ) sat (
    .pix_clk(clk), .rst(s_rst), .enable(1'b1), .pix_valid(1'b0), .pix_data(24'h000000),
    .pix_ready(s_ready), .de(s_de), .hsync(s_hsync), .vsync(s_vsync),
    .red(s_red), .green(s_green), .blue(s_blue), .x(s_x), .y(s_y),
    .frame_start(s_fs), .underrun(s_underrun), .underrun_cnt(s_cnt)
  );
  always @(negedge clk) if (!s_rst && s_underrun) s_pulses++;
  task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic clr();
    de_n = 0; fs_n = 0; hs_n = 0; vs_n = 0; ur_n = 0; hs_first_x = -1;
  endtask
  task automatic step();
    int h, v;
    logic act, miss;
    logic [68:0] e;
    h = m_p % HT;
    v = m_p / HT;
    act = m_run && h < HA && v < VA;
    #1;
    chk("pix_ready", 69'(pix_ready), 69'(act));
    if (rst) begin
      e = {1'b0, 1'b1, 1'b1, 24'h0, 12'h0, 12'h0, 1'b0, 1'b0, 16'h0};
      m_run = 0; m_drain = 0; m_p = 0; m_cnt = 0;
    end else if (!m_run) begin
      e = {1'b0, 1'b1, 1'b1, 24'h0, 12'h0, 12'h0, 1'b0, 1'b0, 16'(m_cnt)};
      if (enable) begin m_run = 1; m_p = 0; m_drain = 0; end
    end else begin
      miss = act && !pix_valid;
      if (miss && m_cnt < 65535) m_cnt++;
      e = {act, !(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
           act ? (pix_valid ? pix_data : FILL) : 24'h0, 12'(h), 12'(v), m_p == 0, miss, 16'(m_cnt)};
      if (m_drain && !enable && m_p == FT - 1) begin m_run = 0; m_p = 0; end
      else m_p = (m_p + 1) % FT;
      m_drain = !enable;
    end
    @(posedge clk);
    #1;
    chk("outputs", {de, hsync, vsync, red, green, blue, x, y, frame_start, underrun, underrun_cnt}, e);
    if (de) de_n++;
    if (frame_start) fs_n++;
    if (!vsync) vs_n++;
    if (underrun) ur_n++;
    if (!hsync) begin hs_n++; if (hs_first_x < 0) hs_first_x = int'(x); end
    @(negedge clk);
  endtask
  task automatic rand_in(input int pct);
    pix_data = $urandom;
    pix_valid = ($urandom_range(99) < pct);
  endtask
  task automatic goto(input int pp);
    for (int i = 0; i < 2 * FT && m_p != pp; i++) begin rand_in(100); step(); end
  endtask
  initial begin
    int n, base, pos;
    rst = 1; s_rst = 1; enable = 0; pix_valid = 0; pix_data = 0;
    m_run = 0; m_drain = 0; m_p = 0; m_cnt = 0;
    clr();
    @(negedge clk);
    repeat (3) step();
    chk("rst_sync", {hsync, vsync}, 2'b11);
    chk("rst_de_ur", {de, frame_start, underrun, underrun_cnt}, 0);
    rst = 0; s_rst = 0;
    repeat (2) step();
    enable = 1; rand_in(100);
    step();
    chk("first_c1_de", 69'(de), 0);
    clr();
    for (int i = 0; i < FT; i++) begin
      rand_in(100);
      step();
      if (i == 0) chk("first_c2", {de, frame_start, x, y}, {1'b1, 1'b1, 24'h0});
    end
    chk("de_per_frame", 69'(de_n), 69'(HA * VA));
    chk("fs_per_frame", 69'(fs_n), 1);
    chk("hsync_low", 69'(hs_n), 69'(HS * VT));
    chk("hsync_first_x", 69'(hs_first_x), 69'(HA + HF));
    chk("vsync_low", 69'(vs_n), 69'(VS * HT));
    chk("no_ur_full_valid", 69'(underrun_cnt), 0);
    for (int i = 0; i < FT; i++) begin rand_in(50); step(); end
    chk("cnt_rand", 69'(underrun_cnt), 69'(m_cnt));
    goto(5 * HT + 3);
    base = m_cnt;
    clr();
    for (int i = 0; i < 10; i++) begin pix_data = $urandom; pix_valid = 0; step(); end
    chk("ur_pulses", 69'(ur_n), 10);
    chk("ur_cnt", 69'(underrun_cnt), 69'(base + 10));
    chk("ur_fill", {red, green, blue}, FILL);
    pix_valid = 1; pix_data = 24'h123456;
    step();
    chk("after_ur_data", {red, green, blue, x}, {24'h123456, 12'd13});
    goto(5 * HT);
    enable = 0;
    n = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      rand_in(100); step(); n++;
      if (x == 12'(HT - 1) && y == 12'(VT - 1)) break;
    end
    chk("drain_len", 69'(n), 69'(FT - 5 * HT));
    step();
    chk("drain_idle", {de, x, y, pix_ready}, 0);
    step();
    chk("idle_hold", {de, frame_start, x, y}, 0);
    enable = 1;
    step();
    goto(3 * HT);
    step();
    pos = int'(y) * HT + int'(x);
    enable = 0;
    repeat (40) begin rand_in(80); step(); end
    enable = 1;
    repeat (20) begin rand_in(80); step(); end
    chk("drain_resume", 69'(int'(y) * HT + int'(x)), 69'(pos + 60));
    goto(5 * HT + 10);
    step();
    rst = 1;
    step();
    chk("mid_rst", {de, hsync, vsync, red, green, blue, x, y, frame_start, underrun, underrun_cnt},
        {1'b0, 1'b1, 1'b1, 24'h0, 12'h0, 12'h0, 1'b0, 1'b0, 16'h0});
    rst = 0;
    step();
    step();
    chk("restart", {de, frame_start, x, y}, {1'b1, 1'b1, 24'h0});
    for (int i = 0; i < 80000 && s_pulses < 65540; i++) begin rand_in(70); step(); end
    chk("sat_reached", 69'(s_pulses > 65535), 1);
    chk("sat_cnt", 69'(s_cnt), 69'(16'hFFFF));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
